// File: rtl/mem_port_unit_if.sv
// Shared instruction/data memory port between the multicycle control unit and the memory responder.
// The master side issues requests; the slave side returns completion status and the IR/MDR values.
interface mem_port_unit_if;
   logic        req;
   logic        iord;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        busy;
   logic [31:0] ir_out;
   logic [31:0] mdr_out;
   logic        ir_valid;
   logic        addr_err;

   modport master (
      output req, iord, we, addr, wdata,
      input  ready, busy, ir_out, mdr_out, ir_valid, addr_err
   );

   modport slave (
      input  req, iord, we, addr, wdata,
      output ready, busy, ir_out, mdr_out, ir_valid, addr_err
   );
endinterface

// File: rtl/mem_port_unit.sv
// Memory-side responder for the shared IorD port: latches a request, waits a fixed number of
// cycles, performs one word access on the internal RAM and pulses ready for a single cycle.
module mem_port_unit #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   mem_port_unit_if.slave bus
);
   localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        iord_q, iord_d;
   logic        we_q, we_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic        ir_valid_q, ir_valid_d;
   logic        addr_err_q, addr_err_d;

   logic [31:0]     ram_q [DEPTH_WORDS];
   logic [IdxW-1:0] idx;
   logic [31:0]     rd_word;
   logic            acc_err;
   logic            ram_we;

   assign idx     = addr_q[IdxW+1:2];
   assign rd_word = ram_q[idx];
   assign acc_err = (addr_q[1:0] != 2'b00) || (32'(addr_q[31:2]) >= DEPTH_WORDS) ||
                    (we_q && !iord_q);
   // Gated by rst so a reset landing on the ACCESS edge aborts the write.
   assign ram_we  = (state_q == StAccess) && !acc_err && iord_q && we_q && !rst;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      iord_d     = iord_q;
      we_d       = we_q;
      ir_d       = ir_q;
      mdr_d      = mdr_q;
      ir_valid_d = ir_valid_q;
      addr_err_d = addr_err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               addr_d     = bus.addr;
               wdata_d    = bus.wdata;
               iord_d     = bus.iord;
               we_d       = bus.we;
               cnt_d      = 4'(WAIT_CYCLES);
               addr_err_d = 1'b0;
               state_d    = (WAIT_CYCLES == 0) ? StAccess : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StAccess;
         end
         StAccess: begin
            state_d = StDone;
            if (acc_err) begin
               addr_err_d = 1'b1;
            end else if (!iord_q) begin
               ir_d       = rd_word;
               ir_valid_d = 1'b1;
            end else if (!we_q) begin
               mdr_d = rd_word;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      ready_d = (state_d == StDone);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         iord_q     <= 1'b0;
         we_q       <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         ir_q       <= 32'h0;
         mdr_q      <= 32'h0;
         ir_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         iord_q     <= iord_d;
         we_q       <= we_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         ir_q       <= ir_d;
         mdr_q      <= mdr_d;
         ir_valid_q <= ir_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram_q[idx] <= wdata_q;
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = busy_q;
   assign bus.ir_out   = ir_q;
   assign bus.mdr_out  = mdr_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_mem_port_unit.sv
// Directed bench for mem_port_unit: a reference model fills a scoreboard as requests are issued
// and each ready pulse pops and checks one entry; a second zero-wait instance checks throughput.
module tb_mem_port_unit;
   localparam int unsigned W     = 2;
   localparam int unsigned DEPTH = 1024;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] mdr;
      logic        irv;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   exp_t        sb_q[$];
   logic [31:0] m_ram [int];
   logic [31:0] m_ir  = 32'h0;
   logic [31:0] m_mdr = 32'h0;
   logic        m_irv = 1'b0;

   mem_port_unit_if bus ();
   mem_port_unit_if bus0 ();

   mem_port_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   mem_port_unit #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic iord, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
      exp_t e;
      logic err;
      int   idx;
      err = (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= DEPTH) || (we && !iord);
      idx = int'(addr[31:2]);
      if (!err) begin
         if (!iord) begin
            m_ir  = m_ram[idx];
            m_irv = 1'b1;
         end else if (we) begin
            m_ram[idx] = wdata;
         end else begin
            m_mdr = m_ram[idx];
         end
      end
      e = '{ir: m_ir, mdr: m_mdr, irv: m_irv, err: err};
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      check({tag, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, " ir_out"}, bus.ir_out, e.ir);
         check({tag, " mdr_out"}, bus.mdr_out, e.mdr);
         check({tag, " ir_valid"}, 32'(bus.ir_valid), 32'(e.irv));
         check({tag, " addr_err"}, 32'(bus.addr_err), 32'(e.err));
      end
   endtask

   task automatic xact(input string tag, input logic iord, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
      int cyc;
      bit seen;
      push_exp(iord, we, addr, wdata);
      @(negedge clk);
      bus.req   = 1'b1;
      bus.iord  = iord;
      bus.we    = we;
      bus.addr  = addr;
      bus.wdata = wdata;
      @(posedge clk);
      #1 bus.req = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ready) seen = 1'b1;
      end
      check({tag, " latency"}, 32'(cyc), 32'(W + 2));
      if (seen) begin
         check({tag, " busy_at_ready"}, 32'(bus.busy), 32'd1);
         pop_check(tag);
      end else if (sb_q.size() != 0) begin
         sb_q.delete(0);
      end
      @(negedge clk);
      check({tag, " ready_drop"}, 32'(bus.ready), 32'd0);
      check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int       nrdy;
      int       first;
      logic [8:0] mask;

      bus.req   = 1'b0;
      bus.iord  = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
      bus0.req   = 1'b0;
      bus0.iord  = 1'b0;
      bus0.we    = 1'b0;
      bus0.addr  = 32'h0;
      bus0.wdata = 32'h0;

      u_dut.ram_q[4]  = 32'h8C22_0010;  m_ram[4]  = 32'h8C22_0010;
      u_dut.ram_q[0]  = 32'hA5A5_0000;  m_ram[0]  = 32'hA5A5_0000;
      u_dut.ram_q[9]  = 32'h0BAD_0009;  m_ram[9]  = 32'h0BAD_0009;
      u_dut.ram_q[12] = 32'h1234_5678;  m_ram[12] = 32'h1234_5678;
      u_dut0.ram_q[0] = 32'h1111_0000;
      u_dut0.ram_q[1] = 32'h2222_0001;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst ready", 32'(bus.ready), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst ir_out", bus.ir_out, 32'h0);
      check("rst mdr_out", bus.mdr_out, 32'h0);
      check("rst ir_valid", 32'(bus.ir_valid), 32'd0);
      check("rst addr_err", 32'(bus.addr_err), 32'd0);

      xact("fetch_0x10", 1'b0, 1'b0, 32'h10, 32'h0);
      xact("store_0x20", 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
      xact("load_0x20", 1'b1, 1'b0, 32'h20, 32'h0);
      xact("misaligned", 1'b1, 1'b0, 32'h22, 32'h0);
      xact("out_of_range", 1'b1, 1'b1, 4 * DEPTH, 32'h7777_7777);
      xact("load_0x0", 1'b1, 1'b0, 32'h0, 32'h0);
      xact("write_on_fetch", 1'b0, 1'b1, 32'h24, 32'h5555_5555);
      xact("load_0x24", 1'b1, 1'b0, 32'h24, 32'h0);

      // req held high while busy: exactly one ready, at the normal latency.
      push_exp(1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      bus.req  = 1'b1;
      bus.iord = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 32'h10;
      @(posedge clk);
      nrdy  = 0;
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.ready) begin
            nrdy++;
            if (first == 0) begin
               first = k;
               pop_check("held_req");
            end
            bus.req = 1'b0;
         end
      end
      check("held_req ready_count", 32'(nrdy), 32'd1);
      check("held_req ready_pos", 32'(first), 32'(W + 2));

      // Reset during WAIT of a write aborts it and clears every output.
      @(negedge clk);
      bus.req   = 1'b1;
      bus.iord  = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 32'h30;
      bus.wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort ready", 32'(bus.ready), 32'd0);
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort ir_out", bus.ir_out, 32'h0);
      check("abort mdr_out", bus.mdr_out, 32'h0);
      check("abort ir_valid", 32'(bus.ir_valid), 32'd0);
      check("abort addr_err", 32'(bus.addr_err), 32'd0);
      rst   = 1'b0;
      m_ir  = 32'h0;
      m_mdr = 32'h0;
      m_irv = 1'b0;
      xact("load_0x30", 1'b1, 1'b0, 32'h30, 32'h0);

      // Zero-wait instance, back-to-back fetches with req held continuously.
      @(negedge clk);
      bus0.req  = 1'b1;
      bus0.iord = 1'b0;
      bus0.we   = 1'b0;
      bus0.addr = 32'h0;
      @(posedge clk);
      mask = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         mask[k] = bus0.ready;
         if (k == 2) begin
            check("w0 first ir_out", bus0.ir_out, 32'h1111_0000);
            bus0.addr = 32'h4;
         end
         if (k == 3) check("w0 idle_gap busy", 32'(bus0.busy), 32'd0);
         if (k == 5) begin
            check("w0 second ir_out", bus0.ir_out, 32'h2222_0001);
            check("w0 ir_valid", 32'(bus0.ir_valid), 32'd1);
            bus0.req = 1'b0;
         end
      end
      check("w0 ready_pattern", 32'(mask), 32'h0000_0024);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
